// File: rtl/serial_word_feeder_if.sv
// Parallel-in / serial-out handshake bundle for serial_word_feeder.
// The master drives words in; the slave (the feeder) returns the serial stream.
interface serial_word_feeder_if #(
  parameter int W = 8
);
  localparam int IW = $clog2(W);

  logic [W-1:0]  din;
  logic          load;
  logic          ready;
  logic          ser_out;
  logic          ser_valid;
  logic [IW-1:0] bit_idx;
  logic          done;

  modport master (
    output din,
    output load,
    input  ready,
    input  ser_out,
    input  ser_valid,
    input  bit_idx,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output ser_out,
    output ser_valid,
    output bit_idx,
    output done
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Serial word feeder: accepts a W-bit word on a load/ready handshake and
// presents it one bit per clock on ser_out, qualified by ser_valid.
// Bit order (LSB_FIRST) and the idle gap after each word (GAP) are fixed.
module serial_word_feeder #(
  parameter int W         = 8,
  parameter int LSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input logic               clk,
  input logic               rst_n,
  serial_word_feeder_if.slave bus
);
  localparam int              IW       = $clog2(W);
  localparam logic [IW-1:0]   LAST_IDX = IW'(W - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state;
  logic [W-1:0]  shreg;      // bits still to be presented, next one at the head
  logic [IW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          ser_out_q;
  logic          ser_valid_q;
  logic          done_q;

  logic          last_bit;
  logic          ready_c;
  logic [IW-1:0] cnt_inc;

  // Head bit of a word in the configured transmission order.
  function automatic logic head_bit(input logic [W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[W-1];
  endfunction

  // Word with its head bit removed, zero-filled at the tail.
  function automatic logic [W-1:0] drop_head(input logic [W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Readiness is a pure decode of registered state.
  always_comb begin
    last_bit = (state == S_SHIFT) && (bit_cnt == LAST_IDX);
    ready_c  = (state == S_IDLE) || ((GAP == 0) && last_bit);
    cnt_inc  = bit_cnt + 1'b1;
  end

  // Sequencer: capture, shift out, optional gap; all serial outputs registered.
  // The first bit is registered straight from din at the accepting edge so it
  // appears one cycle later; shreg then holds only the remaining bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            state       <= S_SHIFT;
            ser_out_q   <= head_bit(bus.din);
            shreg       <= drop_head(bus.din);
            bit_cnt     <= '0;
            ser_valid_q <= 1'b1;
            done_q      <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (!last_bit) begin
            ser_out_q <= head_bit(shreg);
            shreg     <= drop_head(shreg);
            bit_cnt   <= cnt_inc;
            done_q    <= (cnt_inc == LAST_IDX);
          end else if (GAP > 0) begin
            state       <= S_GAP;
            gap_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
          end else if (bus.load) begin
            // Contiguous reload: next word's first bit follows with no bubble.
            ser_out_q   <= head_bit(bus.din);
            shreg       <= drop_head(bus.din);
            bit_cnt     <= '0;
            ser_valid_q <= 1'b1;
            done_q      <= 1'b0;
          end else begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_c;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.bit_idx   = bit_cnt;
  assign bus.done      = done_q;
endmodule
